// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus for the register-file arbiter: two producer handshakes, decode
// hazard query, and the registered write port toward the register file.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic                   alu_valid;
    logic [ADDR_W-1:0]      alu_rd;
    logic [DATA_W-1:0]      alu_data;
    logic                   alu_ready;
    logic                   mem_valid;
    logic [ADDR_W-1:0]      mem_rd;
    logic [DATA_W-1:0]      mem_data;
    logic                   mem_ready;
    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_rd;
    logic [ADDR_W-1:0]      Read_Reg1;
    logic [ADDR_W-1:0]      Read_Reg2;
    logic                   hazard1;
    logic                   hazard2;
    logic [2**ADDR_W-1:0]   busy;
    logic                   RegWrite;
    logic [ADDR_W-1:0]      Write_Reg;
    logic [DATA_W-1:0]      Write_Data;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd, Read_Reg1, Read_Reg2,
        input  alu_ready, mem_ready, hazard1, hazard2, busy,
               RegWrite, Write_Reg, Write_Data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               issue_valid, issue_rd, Read_Reg1, Read_Reg2,
        output alu_ready, mem_ready, hazard1, hazard2, busy,
               RegWrite, Write_Reg, Write_Data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between load and ALU writebacks (loads
// first, with a starvation guard for the ALU) and tracks pending writes per register.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              alu_gnt;
    logic              mem_gnt;
    logic              xfer;
    logic [ADDR_W-1:0] gnt_rd;
    logic [DATA_W-1:0] gnt_data;

    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (bus.alu_valid && (!bus.mem_valid || starve_q == STARVE_LIM)) begin
                alu_gnt = 1'b1;
            end else if (bus.mem_valid) begin
                mem_gnt = 1'b1;
            end
        end
        xfer     = alu_gnt | mem_gnt;
        gnt_rd   = alu_gnt ? bus.alu_rd   : bus.mem_rd;
        gnt_data = alu_gnt ? bus.alu_data : bus.mem_data;
    end

    // A mem win with both valid implies starve_q < STARVE_MAX, so the increment cannot overflow.
    always_comb begin
        starve_d = starve_q;
        if (bus.alu_valid && bus.mem_valid && mem_gnt) begin
            starve_d = starve_q + CNT_W'(1);
        end else if (alu_gnt || !bus.alu_valid) begin
            starve_d = '0;
        end

        regwrite_d = xfer;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (xfer) begin
            wreg_d  = gnt_rd;
            wdata_d = gnt_data;
        end

        // Issue is applied after the clear so a re-issued register stays busy.
        busy_d = busy_q;
        if (xfer) begin
            busy_d[gnt_rd] = 1'b0;
        end
        if (bus.issue_valid) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= '0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
        end else begin
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.alu_ready  = alu_gnt;
    assign bus.mem_ready  = mem_gnt;
    assign bus.RegWrite   = regwrite_q;
    assign bus.Write_Reg  = wreg_q;
    assign bus.Write_Data = wdata_q;
    assign bus.busy       = busy_q;

    // The write-port term covers the cycle before the register file has committed.
    assign bus.hazard1 = !rst && (busy_q[bus.Read_Reg1] || (regwrite_q && wreg_q == bus.Read_Reg1));
    assign bus.hazard2 = !rst && (busy_q[bus.Read_Reg2] || (regwrite_q && wreg_q == bus.Read_Reg2));
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and scoreboard for the 8-entry, 8-bit register file. It shares the register file's single write port between two producers, the ALU result path and the memory-load path. Loads have priority, and a starvation counter guarantees ALU forward progress. It also keeps a per-register busy scoreboard so decode can detect read-after-write hazards on the two read ports.

## Interface
Parameters:
- DATA_W, 8, data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- STARVE_MAX, 3, consecutive ALU losses before ALU is forced to win

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- mem_valid  in  1  load writeback request
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle (combinational)
- issue_valid  in  1  an instruction with a destination register issues this cycle
- issue_rd  in  ADDR_W  its destination register
- Read_Reg1, Read_Reg2  in  ADDR_W  decode read addresses to check
- hazard1, hazard2  out  1  read of Read_Reg1 / Read_Reg2 not yet safe (combinational)
- busy  out  2**ADDR_W  scoreboard vector, bit r = write to r pending
- RegWrite  out  1  register file write enable (registered)
- Write_Reg  out  ADDR_W  register file write address (registered)
- Write_Data  out  DATA_W  register file write data (registered)

## Operation
- **Handshake.**
  - A transfer occurs when valid and ready are both high at a rising edge.
  - A source holds valid, rd and data stable until it sees ready.
  - At most one ready is high in any cycle.
- **Grant rules:**
  - Only one source valid: that source gets ready.
  - Both valid and starve_cnt < STARVE_MAX: mem wins.
  - Both valid and starve_cnt == STARVE_MAX: alu wins.
  - Neither valid: both readies are 0.
- **starve_cnt** (internal, width clog2(STARVE_MAX+1)):
  - Increments on each edge where both sources are valid and mem is granted.
  - Resets to 0 on an edge where alu is granted or alu_valid is 0.
  - Otherwise holds.
  - It never exceeds STARVE_MAX.
- **Write port.**
  - On a transfer edge: RegWrite<=1, Write_Reg<=granted rd, Write_Data<=granted data.
  - On an edge with no transfer: RegWrite<=0, and Write_Reg/Write_Data hold their previous values.
- **Scoreboard.**
  - On issue_valid: busy[issue_rd]<=1.
  - On a transfer: busy[granted rd]<=0.
  - Same edge, same register: the set wins, because a newer producer exists.
  - issue_valid does not stall and is not checked against busy; decode must stall on hazards.
- **Hazards.**
  - hazardN = busy[Read_RegN] | (RegWrite & Write_Reg==Read_RegN).
  - The second term covers the cycle in which the write is presented but not yet committed in the register file.
- Both sources may target the same register. Writes commit in grant order.

## Timing
- **Reset.** Asserting rst asynchronously sets all of the following to 0:
  - RegWrite, Write_Reg, Write_Data
  - busy
  - starve_cnt
- **While rst is high:**
  - alu_ready and mem_ready are forced to 0.
  - hazard1 and hazard2 evaluate to 0.
- **Reset mid-operation.** Any in-flight write or pending scoreboard bit is discarded. No write is issued after reset deasserts until a new handshake occurs.
- **Latency:**
  - Handshake at edge E.
  - RegWrite is high during the cycle after E.
  - The register file commits at edge E+1.
  - A read in the cycle after E+1 returns the new value.
  - hazard for that register deasserts in the cycle after E+1, unless it was re-issued.
- **Throughput.** One write per cycle. Back-to-back transfers keep RegWrite high continuously.
- **Forced ALU win.** After STARVE_MAX consecutive ALU losses, the next cycle with both valid grants ALU. The worst-case ALU wait is therefore STARVE_MAX+1 cycles.

## Test plan
- **Reset:** assert rst mid-stream with busy=8'h0C and RegWrite=1 -> all outputs read 0 immediately (asynchronously); readies are 0 while rst is high.
- **Single source:** issue_rd=5, then alu_valid with alu_rd=5, alu_data=8'hA7 -> alu_ready=1, RegWrite=1/Write_Reg=5/Write_Data=8'hA7 the next cycle, R5=8'hA7 one edge later; busy[5] clears at the handshake edge, and hazard on Read_Reg1=5 stays high through the RegWrite cycle.
- **Priority:** alu and mem both valid for 6 cycles (STARVE_MAX=3) -> grant sequence is mem, mem, mem, alu, then mem (ALU has completed, so only the pending mem requests remain).
- **Collision:** same edge with issue_valid, issue_rd=2 and a writeback to rd=2 -> busy[2] remains 1 afterwards.
- **Same-register writes:** mem (rd=1, 8'h11) and alu (rd=1, 8'h22) both valid -> Write_Data sequence is 8'h11 then 8'h22, and R1 ends at 8'h22.
- **Idle/hold:** after a write, no valids for 3 cycles -> RegWrite=0, and Write_Reg/Write_Data unchanged.
